// File: rtl/sum_uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : sum_uart_pkg
// Purpose : Shared frame geometry, FSM state encoding and parity helper for
//           the sum-and-transmit UART.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
package sum_uart_pkg;

  // 9-bit sum (carry kept) sent LSB first, framed by start/parity/stop
  localparam int DATA_BITS  = 9;
  localparam int FRAME_BITS = 12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;

  // Even parity: the parity bit makes the total count of ones even
  function automatic logic even_parity(input logic [DATA_BITS-1:0] d);
    return ^d;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sum_uart_baud_cnt.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : sum_uart_baud_cnt
// Purpose : Bit-period counter. Counts 0..CLKS_PER_BIT-1 and wraps; tick is
//           high on the last cycle of every bit period.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module sum_uart_baud_cnt #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int                c_cnt_w = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [c_cnt_w-1:0] c_last = c_cnt_w'(CLKS_PER_BIT - 1);

  logic [c_cnt_w-1:0] r_cnt;

  // Free-running modulo counter, held at zero while the transmitter is idle
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_cnt <= '0;
    end else if (r_cnt == c_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign tick = (r_cnt == c_last);

endmodule
`default_nettype wire

// File: rtl/sum_uart_tx.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module  : sum_uart_tx
// Purpose : Accepts an 8-bit operand pair, latches the 9-bit sum and sends
//           it as a 12-bit serial frame: start, 9 data bits LSB first,
//           even parity, stop.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module sum_uart_tx #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] a_i,
  input  logic [7:0] b_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic [8:0] sum_o
);

  import sum_uart_pkg::*;

  localparam logic [3:0] c_last_bit = 4'(DATA_BITS - 1);

  state_e     r_state;
  logic [8:0] r_sum;
  logic [3:0] r_bit_idx;
  logic       r_tx;
  logic       w_tick;
  logic       w_clear;
  logic       w_xfer;

  assign ready_o = (r_state == ST_IDLE);
  assign busy_o  = ~ready_o;
  assign w_xfer  = valid_i && ready_o;
  assign w_clear = (r_state == ST_IDLE);
  assign tx_o    = r_tx;
  assign sum_o   = r_sum;

  // The counter is cleared in IDLE so the first bit period starts aligned
  // with the transfer edge.
  sum_uart_baud_cnt #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud_cnt (
    .clk  (clk),
    .rst  (rst),
    .clear(w_clear),
    .tick (w_tick)
  );

  // Frame sequencer: tx is registered and updated on the same edge as the
  // state, so each bit appears one cycle after the edge that selects it.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_sum     <= '0;
      r_bit_idx <= '0;
      r_tx      <= 1'b1;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_tx <= 1'b1;
          if (w_xfer) begin
            r_sum   <= {1'b0, a_i} + {1'b0, b_i};
            r_tx    <= 1'b0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_tick) begin
            r_state   <= ST_DATA;
            r_bit_idx <= '0;
            r_tx      <= r_sum[0];
          end
        end
        ST_DATA: begin
          if (w_tick) begin
            if (r_bit_idx == c_last_bit) begin
              r_state   <= ST_PARITY;
              r_bit_idx <= '0;
              r_tx      <= even_parity(r_sum);
            end else begin
              r_bit_idx <= r_bit_idx + 4'd1;
              r_tx      <= r_sum[r_bit_idx + 4'd1];
            end
          end
        end
        ST_PARITY: begin
          if (w_tick) begin
            r_state <= ST_STOP;
            r_tx    <= 1'b1;
          end
        end
        ST_STOP: begin
          if (w_tick) begin
            r_state <= ST_IDLE;
            r_tx    <= 1'b1;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_bit_idx <= '0;
          r_tx      <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sum_uart_tx.sv
`default_nettype none
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// Module  : tb_sum_uart_tx
// Purpose : Self-checking bench for sum_uart_tx. Expected frames are queued
//           at each accepted transfer and compared by a line monitor.
// Rev     : 1.0  initial release
// ---------------------------------------------------------------------------
module tb_sum_uart_tx;

  localparam int N0 = 4;
  localparam int N1 = 2;

  logic       clk;
  logic       rst;
  logic [7:0] a0, b0, a1, b1;
  logic       v0, v1;
  logic       ready0, tx0, busy0, ready1, tx1, busy1;
  logic [8:0] sum0, sum1;

  int n_vec = 0;
  int n_err = 0;
  logic [11:0] exp_q[$];

  sum_uart_tx #(.CLKS_PER_BIT(N0)) u_dut0 (
    .clk(clk), .rst(rst), .a_i(a0), .b_i(b0), .valid_i(v0),
    .ready_o(ready0), .tx_o(tx0), .busy_o(busy0), .sum_o(sum0)
  );

  sum_uart_tx #(.CLKS_PER_BIT(N1)) u_dut1 (
    .clk(clk), .rst(rst), .a_i(a1), .b_i(b1), .valid_i(v1),
    .ready_o(ready1), .tx_o(tx1), .busy_o(busy1), .sum_o(sum1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [8:0] model_sum(input logic [7:0] a, input logic [7:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Frame bit k is bit k of the vector: start, sum[0..8], parity, stop
  function automatic logic [11:0] model_frame(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    s = model_sum(a, b);
    return {1'b1, ^s, s, 1'b0};
  endfunction

  // Line monitor for the CLKS_PER_BIT=4 instance; a frame cut short by
  // busy dropping (reset) is discarded.
  always begin : mon0
    logic [11:0] cap;
    logic [11:0] e;
    bit          glitch;
    bit          aborted;
    @(negedge clk);
    if (busy0 && tx0 == 1'b0) begin
      cap = '0; glitch = 0; aborted = 0;
      for (int c = 0; c < 12 * N0; c++) begin
        if (c > 0) @(negedge clk);
        if (!busy0) begin
          aborted = 1;
          break;
        end
        if (c % N0 == 0) cap[c / N0] = tx0;
        else if (tx0 !== cap[c / N0]) glitch = 1;
      end
      if (!aborted) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("frame_bits", {20'd0, cap}, {20'd0, e});
          chk("bit_hold", {31'd0, glitch}, 32'd0);
        end
      end
    end
  end

  task automatic xfer0(input logic [7:0] a, input logic [7:0] b);
    int k;
    k = 0;
    while (!ready0 && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!ready0) begin
      chk("ready_timeout", 32'd0, 32'd1);
      return;
    end
    a0 = a; b0 = b; v0 = 1'b1;
    exp_q.push_back(model_frame(a, b));
    @(negedge clk);
    v0 = 1'b0;
    a0 = 8'($urandom); b0 = 8'($urandom);
    chk("sum_o", {23'd0, sum0}, {23'd0, model_sum(a, b)});
  endtask

  task automatic wait_frame0(output int n);
    n = 0;
    while (busy0 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin : stim
    int          n;
    bit          bad;
    logic [11:0] cap1;
    bit          glitch1;
    logic [7:0]  ra, rb;

    rst = 1'b1; v0 = 1'b0; a0 = '0; b0 = '0; v1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    chk("rst_tx", {31'd0, tx0}, 32'd1);
    chk("rst_ready", {31'd0, ready0}, 32'd1);
    chk("rst_busy", {31'd0, busy0}, 32'd0);
    chk("rst_sum", {23'd0, sum0}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Directed operand pairs, including carry into bit 8
    xfer0(8'h05, 8'h03);
    chk("sum_0x008", {23'd0, sum0}, 32'h008);
    wait_frame0(n);
    chk("busy_len", n, 48);
    xfer0(8'hFF, 8'h01);
    chk("sum_0x100", {23'd0, sum0}, 32'h100);
    wait_frame0(n);
    xfer0(8'hFF, 8'hFF);
    chk("sum_0x1FE", {23'd0, sum0}, 32'h1FE);
    wait_frame0(n);

    // valid pulse during a frame must be ignored
    xfer0(8'h05, 8'h03);
    repeat (10) @(negedge clk);
    a0 = 8'h11; b0 = 8'h22; v0 = 1'b1;
    @(negedge clk);
    v0 = 1'b0;
    chk("ignored_sum", {23'd0, sum0}, 32'h008);
    wait_frame0(n);
    repeat (5) @(negedge clk);
    chk("ignored_no_frame", {31'd0, busy0}, 32'd0);

    // Back-to-back frames with valid held high; operands scrambled while busy
    a0 = 8'h12; b0 = 8'h34; v0 = 1'b1;
    exp_q.push_back(model_frame(8'h12, 8'h34));
    @(negedge clk);
    n = 0;
    while (!ready0 && n < 200) begin
      a0 = 8'($urandom); b0 = 8'($urandom);
      n++;
      @(negedge clk);
    end
    chk("b2b_busy_len", n, 48);
    a0 = 8'h9A; b0 = 8'hBC;
    exp_q.push_back(model_frame(8'h9A, 8'hBC));
    @(negedge clk);
    v0 = 1'b0;
    a0 = 8'($urandom); b0 = 8'($urandom);
    chk("b2b_restart", {31'd0, busy0}, 32'd1);
    chk("b2b_sum", {23'd0, sum0}, {23'd0, model_sum(8'h9A, 8'hBC)});
    wait_frame0(n);

    // Random pairs
    for (int i = 0; i < 3; i++) begin
      ra = 8'($urandom); rb = 8'($urandom);
      xfer0(ra, rb);
      wait_frame0(n);
    end

    // Reset 20 cycles into a frame aborts it
    xfer0(8'h05, 8'h03);
    repeat (19) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    chk("abort_tx", {31'd0, tx0}, 32'd1);
    chk("abort_ready", {31'd0, ready0}, 32'd1);
    chk("abort_sum", {23'd0, sum0}, 32'd0);
    bad = 0;
    repeat (30) begin
      @(negedge clk);
      if (tx0 !== 1'b1 || busy0 !== 1'b0) bad = 1;
    end
    chk("abort_line_idle", {31'd0, bad}, 32'd0);

    // Reset wins over a simultaneous transfer
    a0 = 8'h77; b0 = 8'h01; v0 = 1'b1; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; v0 = 1'b0;
    chk("rst_prio_busy", {31'd0, busy0}, 32'd0);
    chk("rst_prio_sum", {23'd0, sum0}, 32'd0);

    // CLKS_PER_BIT=2 instance: 24-cycle frame
    a1 = 8'h05; b1 = 8'h03; v1 = 1'b1;
    @(negedge clk);
    v1 = 1'b0; a1 = 8'h11; b1 = 8'h11;
    cap1 = '0; glitch1 = 0; n = 0;
    while (busy1 && n < 100) begin
      if (n < 24) begin
        if (n % N1 == 0) cap1[n / N1] = tx1;
        else if (tx1 !== cap1[n / N1]) glitch1 = 1;
      end
      n++;
      @(negedge clk);
    end
    chk("n2_busy_len", n, 24);
    chk("n2_frame", {20'd0, cap1}, {20'd0, model_frame(8'h05, 8'h03)});
    chk("n2_hold", {31'd0, glitch1}, 32'd0);
    chk("n2_sum", {23'd0, sum1}, 32'h008);

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("queue_drained", exp_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sum_uart_tx.md
SUM_UART_TX -- requirements
Module: sum_uart_tx

Interface
REQ-001 The block SHALL have parameter CLKS_PER_BIT (default 16): clock cycles per serial bit period, legal range 2..65535.
REQ-002 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst, input, 1: reset, synchronous and active-high.
REQ-004 Port a_i, input, 8: operand A.
REQ-005 Port b_i, input, 8: operand B.
REQ-006 Port valid_i, input, 1: operands valid, request to transmit their sum.
REQ-007 Port ready_o, output, 1: block can accept an operand pair.
REQ-008 Port tx_o, output, 1: serial line, idle high.
REQ-009 Port busy_o, output, 1: a frame is in progress.
REQ-010 Port sum_o, output, 9: latched sum of the last accepted pair.

Function
REQ-011 A transfer SHALL occur on a rising edge where valid_i=1 and ready_o=1; a_i and b_i SHALL be sampled only on that edge.
REQ-012 On transfer, sum_o SHALL load a_i + b_i zero-extended to 9 bits (carry kept in bit 8), visible the next cycle and held until the next transfer.
REQ-013 ready_o SHALL be 1 only in IDLE; busy_o SHALL be exactly the complement of ready_o.
REQ-014 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-015 IDLE -> START on transfer; START -> DATA, DATA -> PARITY (after 9 bits), PARITY -> STOP, STOP -> IDLE, each after CLKS_PER_BIT cycles per bit.
REQ-016 Frame: 1 start bit (0), 9 data bits sum[0] first through sum[8], 1 even-parity bit (XOR of sum[8:0]), 1 stop bit (1); 12 bit periods total.
REQ-017 tx_o SHALL drive the start bit the cycle after the transfer edge (latency 1) and hold each bit exactly CLKS_PER_BIT cycles.
REQ-018 ready_o SHALL return to 1 the cycle after the last STOP cycle, so a frame occupies exactly 12*CLKS_PER_BIT cycles of busy_o=1.
REQ-019 valid_i held high across frames SHALL start the next frame immediately, with no idle bit period between the stop and next start bits.
REQ-020 valid_i and operand changes while busy_o=1 SHALL be ignored; no queueing.
REQ-021 tx_o SHALL be 1 in IDLE and SHALL be glitch-free (registered output).
REQ-022 The bit-period counter SHALL count 0..CLKS_PER_BIT-1 and wrap; the data-bit index SHALL count 0..8 and clear on leaving DATA.

Reset
REQ-023 With rst=1 at a rising edge: state=IDLE, tx_o=1, ready_o=1, busy_o=0, sum_o=0, all counters=0.
REQ-024 Reset asserted mid-frame SHALL abort the frame at the next edge, drive tx_o=1, and no partial frame SHALL resume afterwards.
REQ-025 rst SHALL take priority over a simultaneous transfer; the operands are discarded.

Structure
REQ-026 Package sum_uart_pkg SHALL hold the FSM state enum, DATA_BITS=9 and FRAME_BITS=12.
REQ-027 The bit-period counter SHALL be sub-module sum_uart_baud_cnt (inputs clk, rst, clear; output tick on the last cycle of each bit period).
REQ-028 The counter width SHALL be $clog2(CLKS_PER_BIT).

Verification (CLKS_PER_BIT=4 unless noted)
REQ-029 a=0x05, b=0x03 -> sum_o=0x008; tx_o bits 0, 000100000, 1, 1; busy_o high for 48 cycles.
REQ-030 a=0xFF, b=0x01 -> sum_o=0x100; data bits 000000001 LSB first; parity 1.
REQ-031 a=0xFF, b=0xFF -> sum_o=0x1FE; parity 0; stop bit 1.
REQ-032 valid_i held high with a new pair each accept -> two frames back-to-back; second start bit directly follows first stop bit; second pair is sampled only on the ready edge.
REQ-033 rst pulsed for 1 cycle at cycle 20 of a frame -> tx_o=1, ready_o=1, sum_o=0 the following cycle; line idle until the next valid_i.
REQ-034 valid_i pulsed during busy with a=0x11 -> ignored; sum_o unchanged; frame bits unchanged; repeat REQ-029 with CLKS_PER_BIT=2 -> 24-cycle frame.
